clock_set_ctrl: RTL

- Mode/sequencing controller for the 12-hour digital clock.
- Runs on the system clock and turns a 1 Hz tick plus two debounced buttons (mode, inc) into 1-cycle count enables for the seconds, minutes and hours BCD counters.
- Owns the AM/PM flag, the time-set state machine and the blink blanking of the field being edited.
- Sits between the button debouncers / tick divider and the counter chain.

---
 rtl/clock_set_ctrl_pkg.sv | 19 +
 rtl/clock_set_ctrl_edge_pulse.sv | 24 ++
 rtl/clock_set_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the 12-hour clock set controller: state encodings and hour constants.
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_e;

    localparam logic [3:0] HOUR11_TENS  = 4'd1;
    localparam logic [3:0] HOUR11_UNITS = 4'd1;
    localparam logic [3:0] HOUR12_TENS  = 4'd1;
    localparam logic [3:0] HOUR12_UNITS = 4'd2;

    function automatic logic is_hour_11(input logic [3:0] tens, input logic [3:0] units);
        return (tens == HOUR11_TENS) && (units == HOUR11_UNITS);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_edge_pulse.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a level goes high.
module clock_set_ctrl_edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the 12-hour clock: count enables, AM/PM, time-set FSM, blink.
// Optional inc auto-repeat is enabled by defining CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_DIV    = 25000000,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic       i_sec_cout,
    input  logic       i_min_cout,
    input  logic [3:0] i_hour_tens,
    input  logic [3:0] i_hour_units,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hour_en,
    output logic       o_sec_clr,
    output logic       o_pm,
    output logic [1:0] o_mode,
    output logic       o_hour_blank,
    output logic       o_min_blank
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    if (REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE || BLINK_DIV < 1) begin : g_bad_cfg
        $error("clock_set_ctrl: invalid BLINK_DIV/REPEAT_DELAY/REPEAT_RATE");
    end

    state_e             r_state, w_state_d;
    logic               r_sec_en, r_min_en, r_hour_en, r_sec_clr, r_pm;
    logic               r_hour_blank, r_min_blank;
    logic               w_sec_en_d, w_min_en_d, w_hour_en_d, w_sec_clr_d, w_pm_d;
    logic               w_inc_acc, w_state_chg;
    logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_d;
    logic               r_phase, w_phase_d;
    logic               w_mode_evt, w_inc_pulse, w_inc_evt, w_rep_fire;
    logic               w_in_set;

    clock_set_ctrl_edge_pulse u_mode_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (i_btn_mode),
        .o_pulse (w_mode_evt)
    );

    clock_set_ctrl_edge_pulse u_inc_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (i_btn_inc),
        .o_pulse (w_inc_pulse)
    );

    assign w_in_set = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [REP_W-1:0] r_rep_cnt;

    // Counter holds cycles since the rising edge; reload spaces later events REPEAT_RATE apart.
    assign w_rep_fire = i_btn_inc && w_in_set && (r_rep_cnt == REP_FIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else if (!i_btn_inc || !w_in_set || w_state_chg) begin
            r_rep_cnt <= '0;
        end else if (w_rep_fire) begin
            r_rep_cnt <= REP_RELOAD;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign w_inc_evt = w_inc_pulse | w_rep_fire;

    always_comb begin
        w_state_d   = r_state;
        w_sec_en_d  = 1'b0;
        w_min_en_d  = 1'b0;
        w_hour_en_d = 1'b0;
        w_sec_clr_d = 1'b0;
        w_inc_acc   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (i_tick_1hz) begin
                    w_sec_en_d  = 1'b1;
                    w_min_en_d  = i_sec_cout;
                    w_hour_en_d = i_sec_cout & i_min_cout;
                end
                if (w_mode_evt) w_state_d = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                if (w_mode_evt) begin
                    w_state_d = ST_SET_MIN;
                end else if (w_inc_evt) begin
                    w_hour_en_d = 1'b1;
                    w_inc_acc   = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (w_mode_evt) begin
                    w_state_d   = ST_RUN;
                    w_sec_clr_d = 1'b1;
                end else if (w_inc_evt) begin
                    w_min_en_d = 1'b1;
                    w_inc_acc  = 1'b1;
                end
            end
            default: w_state_d = ST_RUN;
        endcase
        w_pm_d      = r_pm ^ (w_hour_en_d & is_hour_11(i_hour_tens, i_hour_units));
        w_state_chg = (w_state_d != r_state);
    end

    // Any state change or accepted inc restarts the blink visible.
    always_comb begin
        w_blink_cnt_d = r_blink_cnt + 1'b1;
        w_phase_d     = r_phase;
        if (w_state_chg || w_inc_acc) begin
            w_blink_cnt_d = '0;
            w_phase_d     = 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_d = '0;
            w_phase_d     = ~r_phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_sec_en     <= 1'b0;
            r_min_en     <= 1'b0;
            r_hour_en    <= 1'b0;
            r_sec_clr    <= 1'b0;
            r_pm         <= 1'b0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
            r_hour_blank <= 1'b0;
            r_min_blank  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_sec_en     <= w_sec_en_d;
            r_min_en     <= w_min_en_d;
            r_hour_en    <= w_hour_en_d;
            r_sec_clr    <= w_sec_clr_d;
            r_pm         <= w_pm_d;
            r_blink_cnt  <= w_blink_cnt_d;
            r_phase      <= w_phase_d;
            r_hour_blank <= (w_state_d == ST_SET_HOUR) & w_phase_d;
            r_min_blank  <= (w_state_d == ST_SET_MIN) & w_phase_d;
        end
    end

    assign o_sec_en     = r_sec_en;
    assign o_min_en     = r_min_en;
    assign o_hour_en    = r_hour_en;
    assign o_sec_clr    = r_sec_clr;
    assign o_pm         = r_pm;
    assign o_mode       = r_state;
    assign o_hour_blank = r_hour_blank;
    assign o_min_blank  = r_min_blank;

endmodule
